// File: rtl/eth_decap.sv
// NetTLP RX decapsulator: filters Eth/IPv4/UDP/NetTLP frames, strips the 48-byte header, writes TLP payload or command qword.
// Payload write latency 1 cycle; no backpressure on the MAC side; a full FIFO is reported as ovf_err instead.
module eth_decap #(
  parameter logic [15:0] UDP_DPORT    = 16'h3000,
  parameter logic [15:0] UDP_CMD_PORT = 16'h3010,
  parameter bit          CHECK_IPCSUM = 1'b1
) (
  input  logic        eth_clk,
  input  logic        eth_rst_n,
  input  logic        eth_tvalid,
  input  logic        eth_tlast,
  input  logic [7:0]  eth_tkeep,
  input  logic [63:0] eth_tdata,
  input  logic        eth_tuser,
  input  logic [47:0] adapter_reg_srcmac,
  input  logic [31:0] adapter_reg_srcip,
  input  logic        tlp_prog_full,
  input  logic        tlp_full,
  output logic        tlp_wr_en,
  output logic [63:0] tlp_wr_data,
  output logic [7:0]  tlp_wr_keep,
  output logic        tlp_wr_last,
  output logic        tlp_wr_err,
  input  logic        cmd_full,
  output logic        cmd_wr_en,
  output logic [63:0] cmd_wr_data,
  output logic [31:0] rx_ok_count,
  output logic [31:0] rx_drop_count,
  output logic [15:0] seq_gap_count,
  output logic        ovf_err
);

  typedef enum logic [2:0] {
    RX_SYNC, RX_IDLE, RX_HDR, RX_NTHDR, RX_DATA, RX_DROP
  } rx_state_t;

  typedef enum logic [1:0] {CLS_NONE, CLS_TLP, CLS_CMD} port_cls_t;

  rx_state_t state, state_nxt;
  port_cls_t cls, cls_now;

  logic [2:0]  beat_cnt;
  logic        mac_ok, pf_lat, hdr_bad, seq_valid;
  logic [19:0] csum_acc;
  logic [15:0] seq_prev;

  logic [63:0] d;
  logic [15:0] w0, w1, w2, w3;
  logic [47:0] dst_mac;
  logic        mac_match, beat_bad, csum_ok, in_range, hdr_fail;
  logic [19:0] csum_add, csum_tot;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        tlp_we, cmd_we, ok_inc, drop_inc, seq_upd;

  // Big-endian 16-bit wire words in lane pairs (0,1) (2,3) (4,5) (6,7).
  assign d  = eth_tdata;
  assign w0 = {d[7:0],   d[15:8]};
  assign w1 = {d[23:16], d[31:24]};
  assign w2 = {d[39:32], d[47:40]};
  assign w3 = {d[55:48], d[63:56]};

  assign dst_mac   = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
  assign mac_match = (dst_mac == adapter_reg_srcmac) || (dst_mac == 48'hFFFF_FFFF_FFFF);

  always_comb begin
    beat_bad = 1'b0;
    csum_add = 20'd0;
    case (beat_cnt)
      3'd1: begin
        beat_bad = (w2 != 16'h0800) || (d[55:48] != 8'h45);
        csum_add = {4'd0, w3};
      end
      3'd2, 3'd3: begin
        beat_bad = (beat_cnt == 3'd2) ? (d[63:56] != 8'd17)
                                      : (w3 != adapter_reg_srcip[31:16]);
        csum_add = {4'd0, w0} + {4'd0, w1} + {4'd0, w2} + {4'd0, w3};
      end
      3'd4: begin
        beat_bad = (w0 != adapter_reg_srcip[15:0]);
        csum_add = {4'd0, w0};
      end
      default: ;
    endcase
  end

  // End-around carry folded twice; ten words cannot overflow 20 bits.
  assign csum_tot = csum_acc + csum_add;
  assign fold1    = {1'b0, csum_tot[15:0]} + {13'd0, csum_tot[19:16]};
  assign fold2    = fold1[15:0] + {15'd0, fold1[16]};
  assign csum_ok  = (fold2 == 16'hFFFF);

  assign in_range = ({1'b0, w2} >= {1'b0, UDP_DPORT}) &&
                    ({1'b0, w2} <= ({1'b0, UDP_DPORT} + 17'd15));
  assign cls_now  = (w2 == UDP_CMD_PORT) ? CLS_CMD : (in_range ? CLS_TLP : CLS_NONE);
  assign hdr_fail = hdr_bad || beat_bad || !mac_ok || (CHECK_IPCSUM && !csum_ok);

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) state <= RX_SYNC;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tlp_we    = 1'b0;
    cmd_we    = 1'b0;
    ok_inc    = 1'b0;
    drop_inc  = 1'b0;
    seq_upd   = 1'b0;
    case (state)
      RX_SYNC: if (!eth_tvalid) state_nxt = RX_IDLE;
      RX_IDLE: if (eth_tvalid) begin
        if (eth_tlast) drop_inc = 1'b1;
        else           state_nxt = RX_HDR;
      end
      RX_HDR: if (eth_tvalid) begin
        if (eth_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = RX_IDLE;
        end else if (beat_cnt == 3'd4) begin
          if (hdr_fail || cls_now == CLS_NONE || (cls_now == CLS_TLP && pf_lat))
            state_nxt = RX_DROP;
          else
            state_nxt = RX_NTHDR;
        end
      end
      RX_NTHDR: if (eth_tvalid) begin
        if (cls == CLS_TLP) begin
          if (eth_tlast) begin
            drop_inc  = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            seq_upd   = 1'b1;
            state_nxt = RX_DATA;
          end
        end else if (eth_tlast) begin
          state_nxt = RX_IDLE;
          if (!eth_tuser && !cmd_full) begin
            cmd_we = 1'b1;
            ok_inc = 1'b1;
          end else begin
            drop_inc = 1'b1;
          end
        end else begin
          state_nxt = RX_DROP;
        end
      end
      RX_DATA: if (eth_tvalid) begin
        tlp_we = 1'b1;
        if (eth_tlast) begin
          ok_inc    = 1'b1;
          state_nxt = RX_IDLE;
        end
      end
      RX_DROP: if (eth_tvalid && eth_tlast) begin
        drop_inc  = 1'b1;
        state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_SYNC;
    endcase
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      beat_cnt <= 3'd0;
      mac_ok   <= 1'b0;
      pf_lat   <= 1'b0;
      hdr_bad  <= 1'b0;
      csum_acc <= 20'd0;
      cls      <= CLS_NONE;
    end else if (eth_tvalid) begin
      if (state == RX_IDLE) begin
        beat_cnt <= 3'd1;
        mac_ok   <= mac_match;
        pf_lat   <= tlp_prog_full;
        hdr_bad  <= 1'b0;
        csum_acc <= 20'd0;
      end else if (state == RX_HDR) begin
        beat_cnt <= beat_cnt + 3'd1;
        hdr_bad  <= hdr_bad | beat_bad;
        csum_acc <= csum_tot;
        if (beat_cnt == 3'd4) cls <= cls_now;
      end
    end
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      tlp_wr_en     <= 1'b0;
      tlp_wr_data   <= 64'd0;
      tlp_wr_keep   <= 8'd0;
      tlp_wr_last   <= 1'b0;
      tlp_wr_err    <= 1'b0;
      cmd_wr_en     <= 1'b0;
      cmd_wr_data   <= 64'd0;
      rx_ok_count   <= 32'd0;
      rx_drop_count <= 32'd0;
      seq_gap_count <= 16'd0;
      ovf_err       <= 1'b0;
      seq_valid     <= 1'b0;
      seq_prev      <= 16'd0;
    end else begin
      tlp_wr_en <= tlp_we;
      if (tlp_we) begin
        tlp_wr_data <= {d[39:32], d[47:40], d[55:48], d[63:56],
                        d[7:0],   d[15:8],  d[23:16], d[31:24]};
        tlp_wr_keep <= {eth_tkeep[4], eth_tkeep[5], eth_tkeep[6], eth_tkeep[7],
                        eth_tkeep[0], eth_tkeep[1], eth_tkeep[2], eth_tkeep[3]};
        tlp_wr_last <= eth_tlast;
        tlp_wr_err  <= eth_tuser & eth_tlast;
      end
      cmd_wr_en <= cmd_we;
      if (cmd_we)
        cmd_wr_data <= {d[7:0],   d[15:8],  d[23:16], d[31:24],
                        d[39:32], d[47:40], d[55:48], d[63:56]};
      if (ok_inc)   rx_ok_count   <= rx_ok_count + 32'd1;
      if (drop_inc) rx_drop_count <= rx_drop_count + 32'd1;
      // Seq lives in lanes 2-3 of the NetTLP header beat; 16-bit wrap is not a gap.
      if (seq_upd) begin
        seq_valid <= 1'b1;
        seq_prev  <= w1;
        if (seq_valid && (w1 != seq_prev + 16'd1))
          seq_gap_count <= seq_gap_count + 16'd1;
      end
      ovf_err <= ovf_err | (tlp_wr_en & tlp_full);
    end
  end

endmodule

// File: tb/tb_eth_decap.sv
// Directed bench for eth_decap: hand-built frames, expected payload/counters written out by hand.
module tb_eth_decap;

  logic        eth_clk = 1'b0;
  logic        eth_rst_n;
  logic        eth_tvalid, eth_tlast, eth_tuser;
  logic [7:0]  eth_tkeep;
  logic [63:0] eth_tdata;
  logic [47:0] adapter_reg_srcmac;
  logic [31:0] adapter_reg_srcip;
  logic        tlp_prog_full, tlp_full, cmd_full;

  logic        tlp_wr_en, tlp_wr_last, tlp_wr_err, cmd_wr_en, ovf_err;
  logic [63:0] tlp_wr_data, cmd_wr_data;
  logic [7:0]  tlp_wr_keep;
  logic [31:0] rx_ok_count, rx_drop_count;
  logic [15:0] seq_gap_count;

  logic        nc_wr_en, nc_wr_last, nc_wr_err, nc_cmd_en, nc_ovf;
  logic [63:0] nc_wr_data, nc_cmd_data;
  logic [7:0]  nc_wr_keep;
  logic [31:0] nc_ok, nc_drop;
  logic [15:0] nc_gap;

  always #5 eth_clk = ~eth_clk;

  eth_decap dut (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n),
    .eth_tvalid(eth_tvalid), .eth_tlast(eth_tlast), .eth_tkeep(eth_tkeep),
    .eth_tdata(eth_tdata), .eth_tuser(eth_tuser),
    .adapter_reg_srcmac(adapter_reg_srcmac), .adapter_reg_srcip(adapter_reg_srcip),
    .tlp_prog_full(tlp_prog_full), .tlp_full(tlp_full),
    .tlp_wr_en(tlp_wr_en), .tlp_wr_data(tlp_wr_data), .tlp_wr_keep(tlp_wr_keep),
    .tlp_wr_last(tlp_wr_last), .tlp_wr_err(tlp_wr_err),
    .cmd_full(cmd_full), .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
    .rx_ok_count(rx_ok_count), .rx_drop_count(rx_drop_count),
    .seq_gap_count(seq_gap_count), .ovf_err(ovf_err)
  );

  eth_decap #(.CHECK_IPCSUM(1'b0)) dut_nc (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n),
    .eth_tvalid(eth_tvalid), .eth_tlast(eth_tlast), .eth_tkeep(eth_tkeep),
    .eth_tdata(eth_tdata), .eth_tuser(eth_tuser),
    .adapter_reg_srcmac(adapter_reg_srcmac), .adapter_reg_srcip(adapter_reg_srcip),
    .tlp_prog_full(tlp_prog_full), .tlp_full(tlp_full),
    .tlp_wr_en(nc_wr_en), .tlp_wr_data(nc_wr_data), .tlp_wr_keep(nc_wr_keep),
    .tlp_wr_last(nc_wr_last), .tlp_wr_err(nc_wr_err),
    .cmd_full(cmd_full), .cmd_wr_en(nc_cmd_en), .cmd_wr_data(nc_cmd_data),
    .rx_ok_count(nc_ok), .rx_drop_count(nc_drop),
    .seq_gap_count(nc_gap), .ovf_err(nc_ovf)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Write monitor, sampled on the falling edge.
  logic [63:0] wr_dat  [0:255];
  logic [7:0]  wr_keep [0:255];
  logic        wr_last [0:255];
  logic        wr_err  [0:255];
  int          n_wr = 0;
  int          n_cmd = 0;
  logic [63:0] cmd_dat;

  always @(negedge eth_clk) begin
    if (tlp_wr_en && n_wr < 256) begin
      wr_dat[n_wr]  = tlp_wr_data;
      wr_keep[n_wr] = tlp_wr_keep;
      wr_last[n_wr] = tlp_wr_last;
      wr_err[n_wr]  = tlp_wr_err;
      n_wr++;
    end
    if (cmd_wr_en) begin
      cmd_dat = cmd_wr_data;
      n_cmd++;
    end
  end

  logic [7:0] frm [0:255];
  int         flen;

  task automatic build(input logic [31:0] dip, input logic [15:0] dport,
                       input logic [15:0] seq, input int plen);
    int s;
    logic [15:0] cs;
    for (int i = 0; i < 256; i++) frm[i] = 8'h00;
    frm[0] = 8'h02; frm[5] = 8'h01;
    frm[6] = 8'h02; frm[11] = 8'h02;
    frm[12] = 8'h08; frm[13] = 8'h00;
    frm[14] = 8'h45; frm[17] = 8'(34 + plen);
    frm[20] = 8'h40; frm[22] = 8'h40; frm[23] = 8'h11;
    frm[26] = 8'hC0; frm[27] = 8'hA8; frm[28] = 8'h0A; frm[29] = 8'h02;
    frm[30] = dip[31:24]; frm[31] = dip[23:16]; frm[32] = dip[15:8]; frm[33] = dip[7:0];
    frm[34] = 8'h30; frm[36] = dport[15:8]; frm[37] = dport[7:0];
    frm[39] = 8'(14 + plen);
    frm[42] = seq[15:8]; frm[43] = seq[7:0];
    for (int i = 0; i < plen; i++) frm[48 + i] = 8'(8'h10 + i);
    s = 0;
    for (int i = 14; i < 34; i += 2) s += {frm[i], frm[i + 1]};
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    frm[24] = cs[15:8]; frm[25] = cs[7:0];
    flen = 48 + plen;
  endtask

  task automatic drive_beat(input int b, input int nb, input bit tuser);
    for (int k = 0; k < 8; k++) begin
      eth_tdata[8*k +: 8] = (8*b + k < flen) ? frm[8*b + k] : 8'h00;
      eth_tkeep[k]        = (8*b + k < flen);
    end
    eth_tvalid = 1'b1;
    eth_tlast  = (b == nb - 1);
    eth_tuser  = (b == nb - 1) && tuser;
  endtask

  task automatic idle(input int n);
    eth_tvalid = 1'b0; eth_tlast = 1'b0; eth_tuser = 1'b0;
    eth_tdata = 64'd0; eth_tkeep = 8'd0;
    repeat (n) begin @(posedge eth_clk); #1; end
  endtask

  task automatic send_frame(input bit tuser);
    int nb;
    nb = (flen + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      drive_beat(b, nb, tuser);
      @(posedge eth_clk); #1;
    end
    idle(3);
  endtask

  localparam logic [31:0] OWN_IP = 32'hC0A8_0A01;
  int w0;

  initial begin
    eth_rst_n = 1'b0;
    adapter_reg_srcmac = 48'h0200_0000_0001;
    adapter_reg_srcip  = OWN_IP;
    tlp_prog_full = 1'b0; tlp_full = 1'b0; cmd_full = 1'b0;
    eth_tvalid = 1'b0; eth_tlast = 1'b0; eth_tuser = 1'b0;
    eth_tdata = 64'd0; eth_tkeep = 8'd0;
    repeat (3) @(posedge eth_clk);
    #1;
    check("rst_wr_en", tlp_wr_en, 0);
    check("rst_ok", rx_ok_count, 0);
    check("rst_drop", rx_drop_count, 0);
    check("rst_gap", seq_gap_count, 0);
    check("rst_ovf", ovf_err, 0);
    eth_rst_n = 1'b1;
    idle(2);

    // T1: good TLP frame, 3 payload beats
    w0 = n_wr;
    build(OWN_IP, 16'h3005, 16'd7, 24);
    send_frame(1'b0);
    check("t1_nwr", n_wr - w0, 3);
    check("t1_d0", wr_dat[w0], 64'h1415_1617_1011_1213);
    check("t1_d1", wr_dat[w0+1], 64'h1C1D_1E1F_1819_1A1B);
    check("t1_d2", wr_dat[w0+2], 64'h2425_2627_2021_2223);
    check("t1_last1", wr_last[w0+1], 0);
    check("t1_last2", wr_last[w0+2], 1);
    check("t1_keep", wr_keep[w0+2], 8'hFF);
    check("t1_err", wr_err[w0+2], 0);
    check("t1_ok", rx_ok_count, 1);

    // T2: wrong dst IP, then corrupt IP checksum
    w0 = n_wr;
    build(32'hC0A8_0A09, 16'h3005, 16'd8, 8);
    send_frame(1'b0);
    check("t2_ip_nwr", n_wr - w0, 0);
    check("t2_ip_drop", rx_drop_count, 1);
    build(OWN_IP, 16'h3005, 16'd8, 8);
    frm[24] = frm[24] ^ 8'h01;
    send_frame(1'b0);
    check("t2_cs_nwr", n_wr - w0, 0);
    check("t2_cs_drop", rx_drop_count, 2);
    check("t2_nocheck_ok", nc_ok, 2);

    // T3: sequence gaps and 16-bit wrap
    build(OWN_IP, 16'h3000, 16'd9, 8);
    send_frame(1'b0);
    check("t3_gap9", seq_gap_count, 1);
    build(OWN_IP, 16'h300F, 16'hFFFF, 8);
    send_frame(1'b0);
    check("t3_gapffff", seq_gap_count, 2);
    w0 = n_wr;
    build(OWN_IP, 16'h3001, 16'h0000, 5);
    send_frame(1'b0);
    check("t3_gapwrap", seq_gap_count, 2);
    check("t3_part_keep", wr_keep[w0], 8'h8F);
    check("t3_part_dat", wr_dat[w0], 64'h1400_0000_1011_1213);
    check("t3_ok", rx_ok_count, 4);

    // T4: command frame, then same with cmd_full
    build(OWN_IP, 16'h3010, 16'd0, 0);
    for (int i = 0; i < 8; i++) frm[40 + i] = 8'(i + 1);
    send_frame(1'b0);
    check("t4_ncmd", n_cmd, 1);
    check("t4_cmd_dat", cmd_dat, 64'h0102_0304_0506_0708);
    check("t4_ok", rx_ok_count, 5);
    cmd_full = 1'b1;
    send_frame(1'b0);
    cmd_full = 1'b0;
    check("t4_full_ncmd", n_cmd, 1);
    check("t4_full_drop", rx_drop_count, 3);

    // T5: bad-frame flag, prog_full drop, overflow
    w0 = n_wr;
    build(OWN_IP, 16'h3002, 16'd1, 16);
    send_frame(1'b1);
    check("t5_nwr", n_wr - w0, 2);
    check("t5_err0", wr_err[w0], 0);
    check("t5_err1", wr_err[w0+1], 1);
    check("t5_last1", wr_last[w0+1], 1);
    check("t5_ok", rx_ok_count, 6);
    w0 = n_wr;
    tlp_prog_full = 1'b1;
    build(OWN_IP, 16'h3002, 16'd2, 16);
    send_frame(1'b0);
    tlp_prog_full = 1'b0;
    check("t5_pf_nwr", n_wr - w0, 0);
    check("t5_pf_drop", rx_drop_count, 4);
    check("t5_ovf_pre", ovf_err, 0);
    tlp_full = 1'b1;
    send_frame(1'b0);
    tlp_full = 1'b0;
    check("t5_ovf", ovf_err, 1);
    check("t5_ovf_ok", rx_ok_count, 7);
    check("t5_gap", seq_gap_count, 2);

    // T6: reset during beat 3, released mid-frame
    w0 = n_wr;
    build(OWN_IP, 16'h3005, 16'd3, 24);
    for (int b = 0; b < 9; b++) begin
      if (b == 5) eth_rst_n = 1'b1;
      drive_beat(b, 9, 1'b0);
      if (b == 3) begin
        eth_rst_n = 1'b0;
        #1;
        check("t6_rst_ok", rx_ok_count, 0);
        check("t6_rst_ovf", ovf_err, 0);
        check("t6_rst_gap", seq_gap_count, 0);
      end
      @(posedge eth_clk); #1;
    end
    idle(3);
    check("t6_sync_nwr", n_wr - w0, 0);
    check("t6_sync_drop", rx_drop_count, 0);
    build(OWN_IP, 16'h3005, 16'd4, 24);
    send_frame(1'b0);
    check("t6_next_nwr", n_wr - w0, 3);
    check("t6_next_d0", wr_dat[w0], 64'h1415_1617_1011_1213);
    check("t6_next_ok", rx_ok_count, 1);
    check("t6_next_gap", seq_gap_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
